// File: rtl/rom_port_arbiter_if.sv
// Requester-side bus of the ROM port arbiter.
// Requesters use the master modport and the arbiter uses the slave modport.
interface rom_port_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]       rd_data;

    modport master (
        output req, req_addr,
        input  gnt, rd_valid, rd_data
    );

    modport slave (
        input  req, req_addr,
        output gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin sharing of one ROM read port with tagged return.
// Optional ROM_ARB_SCENE_PRIO_EN: scene_state picks a strict-priority requester.
module rom_port_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    rom_port_arbiter_if.slave bus,
    input  logic [3:0]        scene_state,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] nxt;
    logic [IW-1:0] gnt_id;
    logic          found;
    logic          prio;
    logic          tag_v  [RD_LAT];
    logic [IW-1:0] tag_id [RD_LAT];

    always_comb begin
        win   = '0;
        found = 1'b0;
        prio  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && bus.req[IW'((int'(ptr) + i) % N_REQ)]) begin
                win   = IW'((int'(ptr) + i) % N_REQ);
                found = 1'b1;
            end
        end
`ifdef ROM_ARB_SCENE_PRIO_EN
        // Scene codes 1..N_REQ name requesters 0..N_REQ-1; others give no priority.
        if (scene_state != 4'd0 && int'(scene_state) <= N_REQ) begin
            if (bus.req[IW'(scene_state - 4'd1)]) begin
                win   = IW'(scene_state - 4'd1);
                found = 1'b1;
                prio  = 1'b1;
            end
        end
`endif
        nxt = (int'(win) + 1 == N_REQ) ? '0 : win + IW'(1);
    end

`ifndef ROM_ARB_SCENE_PRIO_EN
    logic unused_scene;
    assign unused_scene = ^scene_state;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.gnt      <= '0;
            bus.rd_valid <= '0;
            bus.rd_data  <= '0;
            mem_en       <= 1'b0;
            mem_addr     <= '0;
            ptr          <= '0;
            gnt_id       <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else begin
            mem_en  <= found;
            bus.gnt <= found ? (ONE << win) : '0;
            if (found) begin
                mem_addr <= bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
                gnt_id   <= win;
                if (!prio) ptr <= nxt;
            end
            // The tag enters one cycle after the grant, aligned with the ROM request.
            tag_v[0]  <= mem_en;
            tag_id[0] <= gnt_id;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            bus.rd_valid <= tag_v[RD_LAT-1] ? (ONE << tag_id[RD_LAT-1]) : '0;
            if (tag_v[RD_LAT-1]) bus.rd_data <= mem_dout;
        end
    end

    always_comb begin
        busy = mem_en;
        for (int i = 0; i < RD_LAT; i++) busy = busy | tag_v[i];
    end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a 2-cycle ROM model.
// Build with +define+ROM_ARB_SCENE_PRIO_EN to exercise scene priority.
module tb_rom_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  scene_state = 4'd0;
    logic        mem_en;
    logic [16:0] mem_addr;
    logic [11:0] mem_dout;
    logic        busy;
    logic [11:0] rom_s0;
    logic [11:0] rom_s1;
    int          tests = 0;
    int          fails = 0;
    logic [16:0] addr_tab [4];

    rom_port_arbiter_if #(.N_REQ(4), .ADDR_W(17), .DATA_W(12)) bus();

    rom_port_arbiter #(.N_REQ(4), .ADDR_W(17), .DATA_W(12), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .scene_state(scene_state),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout), .busy(busy)
    );

    always #20 clk = ~clk;

    function automatic logic [11:0] rom_word(input logic [16:0] a);
        return a[11:0] ^ {7'b0, a[16:12]};
    endfunction

    always_ff @(posedge clk) begin
        rom_s0 <= rom_word(mem_addr);
        rom_s1 <= rom_s0;
    end
    assign mem_dout = rom_s1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.req = '0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic set_addrs();
        for (int i = 0; i < 4; i++) bus.req_addr[i*17 +: 17] = addr_tab[i];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = 4'b1111;
        set_addrs();
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if ({bus.gnt, mem_en, bus.rd_valid, busy} !== 10'd0) begin
                fails++;
                $display("FAIL reset_outs: gnt=%b en=%b rv=%b busy=%b want 0",
                         bus.gnt, mem_en, bus.rd_valid, busy);
            end
        end
        tests++;
        if (mem_addr !== 17'd0 || bus.rd_data !== 12'd0) begin
            fails++;
            $display("FAIL reset_regs: addr=%h data=%h want 0", mem_addr, bus.rd_data);
        end
        rst = 1'b1;
        step();
        tests++;
        if (bus.gnt !== 4'b0001 || mem_addr !== addr_tab[0]) begin
            fails++;
            $display("FAIL reset_first_gnt: gnt=%b addr=%h want 0001 %h",
                     bus.gnt, mem_addr, addr_tab[0]);
        end
        bus.req = '0;
        step();
        step();
        step();
        tests++;
        if (bus.rd_valid !== 4'b0001 || bus.rd_data !== rom_word(addr_tab[0])) begin
            fails++;
            $display("FAIL reset_first_rd: rv=%b data=%h want 0001 %h",
                     bus.rd_valid, bus.rd_data, rom_word(addr_tab[0]));
        end
    endtask

    task automatic test_single();
        apply_reset();
        bus.req_addr[2*17 +: 17] = 17'h01234;
        bus.req = 4'b0100;
        step();
        bus.req = '0;
        tests++;
        if (bus.gnt !== 4'b0100 || mem_addr !== 17'h01234 || mem_en !== 1'b1) begin
            fails++;
            $display("FAIL single_gnt: gnt=%b addr=%h en=%b want 0100 01234 1",
                     bus.gnt, mem_addr, mem_en);
        end
        step();
        tests++;
        if (bus.gnt !== 4'b0000 || mem_en !== 1'b0 || mem_addr !== 17'h01234) begin
            fails++;
            $display("FAIL single_idle: gnt=%b en=%b addr=%h want 0000 0 01234",
                     bus.gnt, mem_en, mem_addr);
        end
        step();
        tests++;
        if (bus.rd_valid !== 4'b0000 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_wait: rv=%b busy=%b want 0000 1", bus.rd_valid, busy);
        end
        step();
        tests++;
        if (bus.rd_valid !== 4'b0100 || bus.rd_data !== rom_word(17'h01234)) begin
            fails++;
            $display("FAIL single_rd: rv=%b data=%h want 0100 %h",
                     bus.rd_valid, bus.rd_data, rom_word(17'h01234));
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL single_busy: busy=%b want 0", busy);
        end
        step();
        tests++;
        if (bus.rd_valid !== 4'b0000 || bus.rd_data !== rom_word(17'h01234)) begin
            fails++;
            $display("FAIL single_hold: rv=%b data=%h want 0000 %h",
                     bus.rd_valid, bus.rd_data, rom_word(17'h01234));
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [3:0] exp_v;
        int         pulses;
        pulses = 0;
        apply_reset();
        set_addrs();
        bus.req = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 7) bus.req = '0;
            exp_g = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
            tests++;
            if (bus.gnt !== exp_g || (k < 8 && mem_addr !== addr_tab[k % 4])) begin
                fails++;
                $display("FAIL rr_gnt[%0d]: gnt=%b addr=%h want %b %h",
                         k, bus.gnt, mem_addr, exp_g, addr_tab[k % 4]);
            end
            exp_v = (k >= 3 && k < 11) ? (4'b0001 << ((k - 3) % 4)) : 4'b0000;
            tests++;
            if (bus.rd_valid !== exp_v) begin
                fails++;
                $display("FAIL rr_rv[%0d]: rv=%b want %b", k, bus.rd_valid, exp_v);
            end
            if (exp_v != 4'b0000) begin
                pulses++;
                tests++;
                if (bus.rd_data !== rom_word(addr_tab[(k - 3) % 4])) begin
                    fails++;
                    $display("FAIL rr_data[%0d]: data=%h want %h",
                             k, bus.rd_data, rom_word(addr_tab[(k - 3) % 4]));
                end
            end
        end
        tests++;
        if (pulses != 8 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rr_drain: pulses=%0d busy=%b want 8 0", pulses, busy);
        end
    endtask

    task automatic test_streaming();
        logic [3:0] exp_g;
        apply_reset();
        set_addrs();
        bus.req = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 4) bus.req = 4'b1001;
            if (k == 5) bus.req = 4'b0001;
            exp_g = (k == 5) ? 4'b1000 : 4'b0001;
            tests++;
            if (bus.gnt !== exp_g || mem_en !== 1'b1) begin
                fails++;
                $display("FAIL stream[%0d]: gnt=%b en=%b want %b 1",
                         k, bus.gnt, mem_en, exp_g);
            end
        end
        bus.req = '0;
    endtask

    task automatic test_reset_midflight();
        int stray;
        stray = 0;
        apply_reset();
        set_addrs();
        bus.req = 4'b0010;
        step();
        bus.req = '0;
        tests++;
        if (bus.gnt !== 4'b0010) begin
            fails++;
            $display("FAIL mid_gnt: gnt=%b want 0010", bus.gnt);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            fails++;
            $display("FAIL mid_async: busy=%b en=%b want 0 0", busy, mem_en);
        end
        step();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.rd_valid !== 4'b0000 || busy !== 1'b0) stray++;
        end
        tests++;
        if (stray != 0) begin
            fails++;
            $display("FAIL mid_stray: bad_cycles=%0d want 0", stray);
        end
    endtask

    task automatic test_scene();
        logic [3:0] exp_g [8];
`ifdef ROM_ARB_SCENE_PRIO_EN
        exp_g = '{4'b0100, 4'b0100, 4'b0100, 4'b0100,
                  4'b0001, 4'b0010, 4'b1000, 4'b0001};
`else
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                  4'b0001, 4'b0010, 4'b1000, 4'b0001};
`endif
        apply_reset();
        set_addrs();
        scene_state = 4'd3;
        bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 3) bus.req = 4'b1011;
            tests++;
            if (bus.gnt !== exp_g[k]) begin
                fails++;
                $display("FAIL scene[%0d]: gnt=%b want %b", k, bus.gnt, exp_g[k]);
            end
        end
        bus.req = '0;
        scene_state = 4'd0;
    endtask

    initial begin
        addr_tab = '{17'h00010, 17'h0ABCD, 17'h1F00F, 17'h05A5A};
        bus.req = '0;
        bus.req_addr = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_streaming();
        test_reset_midflight();
        test_scene();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
